// File: rtl/memory_bus_arbiter_if.sv
// Memory-side bus between the arbiter and the SDRAM/SRAM controller.
// The master side is the arbiter and the slave side is the memory controller.
interface memory_bus_arbiter_if;
  logic [26:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_rnw;
  logic        mem_ram_cs;
  logic        mem_sram_cs;
  logic [7:0]  mem_q;
  logic        sdram_ready;
  logic        sdram_done;

  modport master (
    output mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs,
    input  mem_q, sdram_ready, sdram_done
  );

  modport slave (
    input  mem_addr, mem_data, mem_rnw, mem_ram_cs, mem_sram_cs,
    output mem_q, sdram_ready, sdram_done
  );
endinterface

// File: rtl/memory_bus_arbiter.sv
// Three-requester memory bus arbiter: fixed priority for requester 0, round-robin between 1 and 2,
// one transaction at a time with a watchdog on the completion handshake.
module memory_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [26:0] addr0,
  input  logic [26:0] addr1,
  input  logic [26:0] addr2,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  input  logic [7:0]  wdata2,
  input  logic [2:0]  rnw,
  input  logic [2:0]  sram_sel,
  output logic [2:0]  ack,
  output logic [7:0]  q,
  output logic [1:0]  owner,
  output logic        busy,
  output logic        timeout_err,
  memory_bus_arbiter_if.master mem
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [26:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        rnw_q, rnw_d;
  logic        sel_q, sel_d;
  logic        rr_q, rr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  q_q, q_d;
  logic        err_q, err_d;
  logic [1:0]  win;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rnw_d   = rnw_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    err_d   = 1'b0;
    win     = 2'd0;

    // rr_q set means requester 1 was granted last, so requester 2 wins a tie.
    if (req[0])                 win = 2'd0;
    else if (req[1] && req[2])  win = rr_q ? 2'd2 : 2'd1;
    else if (req[1])            win = 2'd1;
    else                        win = 2'd2;

    unique case (state_q)
      StIdle: begin
        if (req != 3'b000 && mem.sdram_ready) begin
          owner_d = win;
          state_d = StIssue;
          if (win != 2'd0) rr_d = (win == 2'd1);
          case (win)
            2'd0: begin
              addr_d = addr0; data_d = wdata0; rnw_d = rnw[0]; sel_d = sram_sel[0];
            end
            2'd1: begin
              addr_d = addr1; data_d = wdata1; rnw_d = rnw[1]; sel_d = sram_sel[1];
            end
            default: begin
              addr_d = addr2; data_d = wdata2; rnw_d = rnw[2]; sel_d = sram_sel[2];
            end
          endcase
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mem.sdram_done) begin
          q_d     = mem.mem_q;
          state_d = StDone;
        end else if (cnt_q == TimeoutLast) begin
          q_d     = 8'hFF;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      owner_q <= 2'd0;
      addr_q  <= 27'd0;
      data_q  <= 8'd0;
      rnw_q   <= 1'b1;
      sel_q   <= 1'b0;
      rr_q    <= 1'b0;
      cnt_q   <= 8'd0;
      q_q     <= 8'h00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rnw_q   <= rnw_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    mem.mem_addr    = addr_q;
    mem.mem_data    = data_q;
    mem.mem_rnw     = rnw_q;
    mem.mem_ram_cs  = (state_q == StIssue) && !sel_q;
    mem.mem_sram_cs = (state_q == StIssue) && sel_q;
    ack             = (state_q == StDone) ? (3'b001 << owner_q) : 3'b000;
    q               = q_q;
    owner           = owner_q;
    busy            = (state_q != StIdle);
    timeout_err     = err_q;
  end

endmodule

// File: tb/tb_memory_bus_arbiter.sv
// Directed bench for memory_bus_arbiter: a table of whole transactions plus a
// hand-written reset-during-WAIT sequence.
module tb_memory_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [26:0] addr0, addr1, addr2;
  logic [7:0]  wdata0, wdata1, wdata2;
  logic [2:0]  rnw, sram_sel;
  logic [2:0]  ack;
  logic [7:0]  q;
  logic [1:0]  owner;
  logic        busy, timeout_err;

  int checks = 0;
  int errors = 0;

  memory_bus_arbiter_if mem_if ();

  memory_bus_arbiter #(.TIMEOUT(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .addr0       (addr0),
    .addr1       (addr1),
    .addr2       (addr2),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .wdata2      (wdata2),
    .rnw         (rnw),
    .sram_sel    (sram_sel),
    .ack         (ack),
    .q           (q),
    .owner       (owner),
    .busy        (busy),
    .timeout_err (timeout_err),
    .mem         (mem_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic [2:0] rnw;
    logic [2:0] sel;
    int         rdy_dly;
    int         done_at;   // WAIT cycle index carrying sdram_done; 255 = never
    logic [7:0] mq;
    logic       drop;
    logic [1:0] exp_owner;
    logic [7:0] exp_q;
    logic       exp_err;
    int         exp_waits;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [26:0] ea;
    logic [7:0]  ed;
    int          waits;
    bit          got;
    case (v.exp_owner)
      2'd0:    begin ea = addr0; ed = wdata0; end
      2'd1:    begin ea = addr1; ed = wdata1; end
      default: begin ea = addr2; ed = wdata2; end
    endcase
    req = v.req; rnw = v.rnw; sram_sel = v.sel; mem_if.mem_q = v.mq;
    mem_if.sdram_done = 1'b0;
    for (int i = 0; i < v.rdy_dly; i++) begin
      mem_if.sdram_ready = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("v%0d not_ready_busy", idx), 32'(busy), 32'd0);
      chk($sformatf("v%0d not_ready_cs", idx),
          32'({mem_if.mem_ram_cs, mem_if.mem_sram_cs}), 32'd0);
    end
    mem_if.sdram_ready = 1'b1;
    @(posedge clk); #1;
    // ISSUE cycle
    chk($sformatf("v%0d issue_busy", idx), 32'(busy), 32'd1);
    chk($sformatf("v%0d owner", idx), 32'(owner), 32'(v.exp_owner));
    chk($sformatf("v%0d ram_cs", idx), 32'(mem_if.mem_ram_cs), 32'(!v.sel[v.exp_owner]));
    chk($sformatf("v%0d sram_cs", idx), 32'(mem_if.mem_sram_cs), 32'(v.sel[v.exp_owner]));
    chk($sformatf("v%0d mem_addr", idx), 32'(mem_if.mem_addr), 32'(ea));
    chk($sformatf("v%0d mem_data", idx), 32'(mem_if.mem_data), 32'(ed));
    chk($sformatf("v%0d mem_rnw", idx), 32'(mem_if.mem_rnw), 32'(v.rnw[v.exp_owner]));
    chk($sformatf("v%0d issue_ack", idx), 32'(ack), 32'd0);
    if (v.drop) req = 3'b000;
    // done during ISSUE must be ignored
    mem_if.sdram_done = (v.done_at != 0);
    @(posedge clk); #1;
    got = 1'b0;
    waits = 0;
    for (int k = 0; k < 20; k++) begin
      mem_if.sdram_done = (k == v.done_at);
      @(posedge clk); #1;
      if (ack != 3'b000) begin
        got = 1'b1;
        waits = k + 1;
        break;
      end
      chk($sformatf("v%0d wait_cs", idx),
          32'({mem_if.mem_ram_cs, mem_if.mem_sram_cs}), 32'd0);
    end
    mem_if.sdram_done = 1'b0;
    chk($sformatf("v%0d ack_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d wait_cycles", idx), 32'(waits), 32'(v.exp_waits));
    chk($sformatf("v%0d ack", idx), 32'(ack), 32'(3'b001 << v.exp_owner));
    chk($sformatf("v%0d q", idx), 32'(q), 32'(v.exp_q));
    chk($sformatf("v%0d timeout_err", idx), 32'(timeout_err), 32'(v.exp_err));
    @(posedge clk); #1;
    chk($sformatf("v%0d ack_one_cycle", idx), 32'(ack), 32'd0);
    chk($sformatf("v%0d idle_busy", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d err_one_cycle", idx), 32'(timeout_err), 32'd0);
    chk($sformatf("v%0d q_hold", idx), 32'(q), 32'(v.exp_q));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " ack"}, 32'(ack), 32'd0);
    chk({tag, " q"}, 32'(q), 32'h00);
    chk({tag, " owner"}, 32'(owner), 32'd0);
    chk({tag, " mem_addr"}, 32'(mem_if.mem_addr), 32'd0);
    chk({tag, " mem_data"}, 32'(mem_if.mem_data), 32'd0);
    chk({tag, " mem_rnw"}, 32'(mem_if.mem_rnw), 32'd1);
    chk({tag, " cs"}, 32'({mem_if.mem_ram_cs, mem_if.mem_sram_cs}), 32'd0);
    chk({tag, " timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    vec_t post;
    // req rnw sel rdy done mq drop owner q err waits
    vecs[0]  = '{3'b001, 3'b111, 3'b000, 0, 1,   8'hA5, 1'b0, 2'd0, 8'hA5, 1'b0, 2};
    vecs[1]  = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h01, 1'b0, 2'd1, 8'h01, 1'b0, 1};
    vecs[2]  = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h02, 1'b0, 2'd2, 8'h02, 1'b0, 1};
    vecs[3]  = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h03, 1'b0, 2'd1, 8'h03, 1'b0, 1};
    vecs[4]  = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h04, 1'b1, 2'd2, 8'h04, 1'b0, 1};
    vecs[5]  = '{3'b111, 3'b111, 3'b000, 0, 2,   8'h05, 1'b0, 2'd0, 8'h05, 1'b0, 3};
    vecs[6]  = '{3'b111, 3'b111, 3'b000, 0, 0,   8'h06, 1'b0, 2'd0, 8'h06, 1'b0, 1};
    vecs[7]  = '{3'b100, 3'b111, 3'b000, 0, 0,   8'h07, 1'b0, 2'd2, 8'h07, 1'b0, 1};
    vecs[8]  = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h08, 1'b0, 2'd1, 8'h08, 1'b0, 1};
    vecs[9]  = '{3'b010, 3'b111, 3'b000, 0, 255, 8'h77, 1'b0, 2'd1, 8'hFF, 1'b1, 4};
    vecs[10] = '{3'b100, 3'b111, 3'b000, 0, 3,   8'h3A, 1'b0, 2'd2, 8'h3A, 1'b0, 4};
    vecs[11] = '{3'b010, 3'b101, 3'b010, 5, 0,   8'hC3, 1'b0, 2'd1, 8'hC3, 1'b0, 1};
    post     = '{3'b110, 3'b111, 3'b000, 0, 0,   8'h99, 1'b0, 2'd1, 8'h99, 1'b0, 1};

    addr0 = 27'h0000100; addr1 = 27'h1234567; addr2 = 27'h7654321;
    wdata0 = 8'h11; wdata1 = 8'h3C; wdata2 = 8'h5A;
    req = 3'b000; rnw = 3'b111; sram_sel = 3'b000;
    mem_if.mem_q = 8'h00; mem_if.sdram_ready = 1'b1; mem_if.sdram_done = 1'b0;

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // Reset during WAIT, then a stray done in IDLE.
    req = 3'b001; rnw = 3'b111; sram_sel = 3'b000; mem_if.mem_q = 8'h5E;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midreset in_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    req = 3'b000;
    mem_if.sdram_done = 1'b1;
    chk_reset_state("midreset");
    @(posedge clk); #1;
    mem_if.sdram_done = 1'b0;
    chk_reset_state("late_done");
    @(posedge clk); #1;
    chk_reset_state("late_done2");

    // Round-robin pointer must be back to requester 1.
    run_vec(post, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
